round_controller: RTL

Game sequencer for the two-player Halli Galli card game. It owns the turn order and the deck count, and it arbitrates the two bell buttons. It issues one-cycle deal pulses to the card generator, samples the card-match flag from the match checker, and emits score-update pulses to the score register. It sits between the keypad scanner and bell buttons on the input side and the deal/score datapath on the output side.

---
 rtl/round_pkg.sv | 25 ++
 rtl/bell_arbiter.sv | 55 +++++
 rtl/round_controller.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/round_pkg.sv
// Shared types and constants for the Halli Galli round sequencer.
package round_pkg;

  typedef enum logic [2:0] {
    ST_WAIT   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_JUDGE  = 3'd2,
    ST_LOCK   = 3'd3,
    ST_OVER   = 3'd4
  } state_e;

  localparam logic [3:0] KEY_NONE    = 4'd0;
  localparam logic [3:0] KEY_FLIP_P1 = 4'd1;
  localparam logic [3:0] KEY_FLIP_P2 = 4'd2;

  localparam logic PLAYER_1 = 1'b0;
  localparam logic PLAYER_2 = 1'b1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bell_arbiter.sv
// Bell edge detection and single-winner arbitration with rotating tie priority.
module bell_arbiter
  import round_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic bell_p1,
  input  logic bell_p2,
  output logic req,
  output logic grant_who
);

  logic p1_prev_q, p1_prev_d;
  logic p2_prev_q, p2_prev_d;
  logic prio_q, prio_d;
  logic rise_p1_s, rise_p2_s;

  // Rising edges, grant selection and tie-priority hand-over.
  always_comb begin
    p1_prev_d = bell_p1;
    p2_prev_d = bell_p2;
    rise_p1_s = bell_p1 & ~p1_prev_q;
    rise_p2_s = bell_p2 & ~p2_prev_q;
    req       = en & (rise_p1_s | rise_p2_s);
    prio_d    = prio_q;
    if (rise_p1_s && rise_p2_s) begin
      grant_who = prio_q;
      // priority only rotates when the tie actually earns a judge
      if (en) begin
        prio_d = ~prio_q;
      end else begin
        prio_d = prio_q;
      end
    end else if (rise_p2_s) begin
      grant_who = PLAYER_2;
    end else begin
      grant_who = PLAYER_1;
    end
  end

  // Edge history and tie-priority registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_prev_q <= 1'b0;
      p2_prev_q <= 1'b0;
      prio_q    <= PLAYER_1;
    end else begin
      p1_prev_q <= p1_prev_d;
      p2_prev_q <= p2_prev_d;
      prio_q    <= prio_d;
    end
  end

endmodule

// File: rtl/round_controller.sv
// Halli Galli round sequencer: turn order, deck count, deal pulses and bell judging.
module round_controller
  import round_pkg::*;
#(
  parameter int DECK_SIZE    = 56,
  parameter int SETTLE_CYC   = 4,
  parameter int LOCK_CYC     = 1000,
  parameter int LAST_TIMEOUT = 50000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [3:0]                     key_code,
  input  logic                           bell_p1,
  input  logic                           bell_p2,
  input  logic                           match,
  output logic                           deal_en,
  output logic                           turn,
  output logic [$clog2(DECK_SIZE+1)-1:0] cards_left,
  output logic                           score_we,
  output logic                           score_who,
  output logic                           score_hit,
  output logic [2:0]                     phase,
  output logic                           game_over
);

  localparam int CNT_W   = $clog2(DECK_SIZE + 1);
  localparam int TMR_MAX = max3(SETTLE_CYC, LOCK_CYC, LAST_TIMEOUT);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [CNT_W-1:0] CARDS_FULL = CNT_W'(DECK_SIZE);
  localparam logic [CNT_W-1:0] CARDS_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CARD_ONE   = CNT_W'(1);
  localparam logic [TMR_W-1:0] TMR_ZERO   = TMR_W'(0);
  localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_SETTLE = TMR_W'(SETTLE_CYC);
  localparam logic [TMR_W-1:0] TMR_LOCK   = TMR_W'(LOCK_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(LAST_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             turn_q, turn_d;
  logic [CNT_W-1:0] cards_q, cards_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [3:0]       key_prev_q, key_prev_d;
  logic             deal_en_q, deal_en_d;
  logic             score_we_q, score_we_d;
  logic             score_who_q, score_who_d;
  logic             score_hit_q, score_hit_d;
  logic             game_over_q, game_over_d;

  logic flip_p1_s, flip_p2_s, flip_turn_s;
  logic arb_en_s, arb_req_s, arb_who_s;

  assign flip_p1_s   = (key_code == KEY_FLIP_P1) && (key_prev_q != KEY_FLIP_P1);
  assign flip_p2_s   = (key_code == KEY_FLIP_P2) && (key_prev_q != KEY_FLIP_P2);
  assign flip_turn_s = turn_q ? flip_p2_s : flip_p1_s;
  // a bell before the first deal never opens a judge
  assign arb_en_s    = (state_q == ST_WAIT) && (cards_q != CARDS_FULL);

  bell_arbiter u_bell_arbiter (
    .clk       (clk),
    .rst       (rst),
    .en        (arb_en_s),
    .bell_p1   (bell_p1),
    .bell_p2   (bell_p2),
    .req       (arb_req_s),
    .grant_who (arb_who_s)
  );

  // Next-state, deck, timer and pulse decode.
  always_comb begin
    state_d     = state_q;
    turn_d      = turn_q;
    cards_d     = cards_q;
    tmr_d       = tmr_q;
    key_prev_d  = key_code;
    deal_en_d   = 1'b0;
    score_we_d  = 1'b0;
    score_who_d = score_who_q;
    score_hit_d = score_hit_q;
    case (state_q)
      ST_WAIT: begin
        if (arb_req_s) begin
          state_d     = ST_JUDGE;
          score_we_d  = 1'b1;
          score_who_d = arb_who_s;
          score_hit_d = match;
        end else if (cards_q != CARDS_ZERO) begin
          if (flip_turn_s) begin
            state_d   = ST_SETTLE;
            deal_en_d = 1'b1;
            cards_d   = cards_q - CARD_ONE;
            turn_d    = ~turn_q;
            tmr_d     = TMR_SETTLE;
          end else begin
            state_d = ST_WAIT;
          end
        end else if (tmr_q == TMR_ZERO) begin
          state_d = ST_OVER;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end
      ST_SETTLE: begin
        if (tmr_q == TMR_ZERO) begin
          state_d = ST_WAIT;
          tmr_d   = TMR_LAST;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end
      ST_JUDGE: begin
        turn_d  = score_hit_q ? score_who_q : ~score_who_q;
        state_d = ST_LOCK;
        tmr_d   = TMR_LOCK;
      end
      ST_LOCK: begin
        if (tmr_q == TMR_ZERO) begin
          state_d = (cards_q == CARDS_ZERO) ? ST_OVER : ST_WAIT;
          tmr_d   = TMR_LAST;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end
      ST_OVER: begin
        state_d = ST_OVER;
      end
      default: begin
        state_d = ST_WAIT;
      end
    endcase
    game_over_d = (state_d == ST_OVER);
  end

  // State, deck, timer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_WAIT;
      turn_q      <= PLAYER_1;
      cards_q     <= CARDS_FULL;
      tmr_q       <= TMR_LAST;
      key_prev_q  <= KEY_NONE;
      deal_en_q   <= 1'b0;
      score_we_q  <= 1'b0;
      score_who_q <= 1'b0;
      score_hit_q <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      turn_q      <= turn_d;
      cards_q     <= cards_d;
      tmr_q       <= tmr_d;
      key_prev_q  <= key_prev_d;
      deal_en_q   <= deal_en_d;
      score_we_q  <= score_we_d;
      score_who_q <= score_who_d;
      score_hit_q <= score_hit_d;
      game_over_q <= game_over_d;
    end
  end

  assign deal_en    = deal_en_q;
  assign turn       = turn_q;
  assign cards_left = cards_q;
  assign score_we   = score_we_q;
  assign score_who  = score_who_q;
  assign score_hit  = score_hit_q;
  assign phase      = state_q;
  assign game_over  = game_over_q;

endmodule
